// File: rtl/mac_dot_accumulator_pkg.sv
// mac_pkg: shared widths, FSM state encoding and helpers for the
// mac_dot_accumulator slice.
//   DATA_W  - operand width (signed 8-bit)
//   PROD_W  - product width (signed 16-bit)
//   ACC_W   - accumulator width (signed 24-bit, wraps modulo 2^24)
//   state_t - sequencing FSM states
package mac_pkg;

  localparam int DATA_W = 8;
  localparam int PROD_W = 16;
  localparam int ACC_W  = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Sign-extend a registered product to accumulator width.
  function automatic logic [ACC_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/mac_dot_accumulator_acc_adder_24.sv
// Adder_8bit: 8-bit adder slice with carry in/out.
//   a, b  - addends
//   cin   - carry in
//   sum   - 8-bit sum
//   cout  - carry out
module Adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  // Single slice sum; the carry chain is formed by the parent.
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
  end

endmodule

// acc_adder_24: 24-bit adder from three chained 8-bit slices.
//   a, b     - 24-bit addends
//   sum      - 24-bit sum (modulo 2^24)
//   top_cin  - carry into the top slice's MSB position is not visible
//              directly, so the carry into bit 23 is rebuilt below
//   top_cout - carry out of bit 23
// top_cin ^ top_cout flags signed overflow of the 24-bit addition.
module acc_adder_24
  import mac_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             top_cin,
  output logic             top_cout
);

  logic c0_s;
  logic c1_s;

  Adder_8bit u_lo (
    .a    (a[7:0]),
    .b    (b[7:0]),
    .cin  (1'b0),
    .sum  (sum[7:0]),
    .cout (c0_s)
  );

  Adder_8bit u_mid (
    .a    (a[15:8]),
    .b    (b[15:8]),
    .cin  (c0_s),
    .sum  (sum[15:8]),
    .cout (c1_s)
  );

  Adder_8bit u_hi (
    .a    (a[23:16]),
    .b    (b[23:16]),
    .cin  (c1_s),
    .sum  (sum[23:16]),
    .cout (top_cout)
  );

  // Carry into the sign bit: sum bit = a ^ b ^ carry_in at that position.
  always_comb begin
    top_cin = sum[ACC_W-1] ^ a[ACC_W-1] ^ b[ACC_W-1];
  end

endmodule

// File: rtl/mac_dot_accumulator.sv
// mac_dot_accumulator: streams signed 8-bit operand pairs, multiplies
// each pair and sums VEC_LEN products into a 24-bit accumulator, then
// presents the dot product on a valid/ready port.
//   clk, rst      - clock, asynchronous active-high reset
//   in_valid/in_ready, in_a, in_b - operand pair handshake
//   out_valid/out_ready, out_sum   - result handshake (modulo 2^24)
//   out_overflow  - sticky signed 24-bit overflow for this vector
module mac_dot_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned VEC_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_overflow
);

  localparam logic [9:0] LAST_CNT = 10'(VEC_LEN);

  state_t             state_r;
  state_t             next_state_s;
  logic [9:0]         count_r;
  logic [PROD_W-1:0]  prod_r;
  logic               prod_vld_r;
  logic [ACC_W-1:0]   acc_r;
  logic               ovf_r;
  logic               in_ready_r;
  logic               out_valid_r;

  logic               accept_s;
  logic               result_taken_s;
  logic               last_pair_s;
  logic [PROD_W-1:0]  a_ext_s;
  logic [PROD_W-1:0]  b_ext_s;
  logic [PROD_W-1:0]  prod_s;
  logic [ACC_W-1:0]   add_sum_s;
  logic               top_cin_s;
  logic               top_cout_s;

  // Handshake qualifiers and the signed product of the presented pair.
  always_comb begin
    accept_s       = in_valid && in_ready_r;
    result_taken_s = out_valid_r && out_ready;
    last_pair_s    = (count_r + 10'd1) == LAST_CNT;
    a_ext_s        = {{(PROD_W-DATA_W){in_a[DATA_W-1]}}, in_a};
    b_ext_s        = {{(PROD_W-DATA_W){in_b[DATA_W-1]}}, in_b};
    // Low 16 bits of the sign-extended product equal the exact signed product.
    prod_s         = a_ext_s * b_ext_s;
  end

  acc_adder_24 u_acc_adder (
    .a        (acc_r),
    .b        (sext_prod(prod_r)),
    .sum      (add_sum_s),
    .top_cin  (top_cin_s),
    .top_cout (top_cout_s)
  );

  // Next-state logic for the vector sequencing FSM.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = last_pair_s ? DRAIN : ACCUM;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCUM: begin
        if (accept_s && last_pair_s) begin
          next_state_s = DRAIN;
        end else begin
          next_state_s = ACCUM;
        end
      end
      DRAIN: begin
        next_state_s = HOLD;
      end
      HOLD: begin
        if (result_taken_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = HOLD;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // FSM state plus handshake flags registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      in_ready_r  <= (next_state_s == IDLE) || (next_state_s == ACCUM);
      out_valid_r <= (next_state_s == HOLD);
    end
  end

  // Accepted-pair counter, cleared when the result is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 10'd0;
    end else if (result_taken_s) begin
      count_r <= 10'd0;
    end else if (accept_s) begin
      count_r <= count_r + 10'd1;
    end else begin
      count_r <= count_r;
    end
  end

  // Stage 1: register the product of each accepted pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_r     <= {PROD_W{1'b0}};
      prod_vld_r <= 1'b0;
    end else begin
      prod_vld_r <= accept_s;
      if (accept_s) begin
        prod_r <= prod_s;
      end else begin
        prod_r <= prod_r;
      end
    end
  end

  // Stage 2: accumulate pending product and track sticky signed overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= {ACC_W{1'b0}};
      ovf_r <= 1'b0;
    end else if (result_taken_s) begin
      acc_r <= {ACC_W{1'b0}};
      ovf_r <= 1'b0;
    end else if (prod_vld_r) begin
      acc_r <= add_sum_s;
      // Carry into and out of the sign bit differ exactly on signed overflow.
      ovf_r <= ovf_r | (top_cin_s ^ top_cout_s);
    end else begin
      acc_r <= acc_r;
      ovf_r <= ovf_r;
    end
  end

  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign out_sum      = acc_r;
  assign out_overflow = ovf_r;

endmodule

// File: tb/tb_mac_dot_accumulator.sv
module tb_mac_dot_accumulator;

  logic        clk;
  logic        rst;
  logic [7:0]  in_a;
  logic [7:0]  in_b;

  logic        v4, r4, ov4, or4, ovf4;
  logic [23:0] sum4;
  logic        v1, r1, ov1, or1, ovf1;
  logic [23:0] sum1;
  logic        v6, r6, ov6, or6, ovf6;
  logic [23:0] sum6;

  int errors = 0;
  int checks = 0;

  mac_dot_accumulator #(.VEC_LEN(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .in_a(in_a), .in_b(in_b),
    .out_valid(ov4), .out_ready(or4), .out_sum(sum4), .out_overflow(ovf4)
  );

  mac_dot_accumulator #(.VEC_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_a(in_a), .in_b(in_b),
    .out_valid(ov1), .out_ready(or1), .out_sum(sum1), .out_overflow(ovf1)
  );

  mac_dot_accumulator #(.VEC_LEN(600)) dut600 (
    .clk(clk), .rst(rst), .in_valid(v6), .in_ready(r6), .in_a(in_a), .in_b(in_b),
    .out_valid(ov6), .out_ready(or6), .out_sum(sum6), .out_overflow(ovf6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one pair to the selected instance for exactly one cycle.
  task automatic push(input int sel, input logic [7:0] a, input logic [7:0] b);
    in_a = a;
    in_b = b;
    v4 = (sel == 4);
    v1 = (sel == 1);
    v6 = (sel == 600);
    @(posedge clk); #1;
    v4 = 1'b0;
    v1 = 1'b0;
    v6 = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    in_a = 8'h00; in_b = 8'h00;
    v4 = 1'b0; v1 = 1'b0; v6 = 1'b0;
    or4 = 1'b1; or1 = 1'b1; or6 = 1'b0;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  {31'd0, r4},   32'd1);
    chk("rst_out_valid", {31'd0, ov4},  32'd0);
    chk("rst_out_sum",   {8'd0, sum4},  32'd0);
    chk("rst_overflow",  {31'd0, ovf4}, 32'd0);
    chk("rst_in_ready_600", {31'd0, r6}, 32'd1);
    rst = 1'b0;
    step();

    // Basic dot product: 1*5+2*6+3*7+4*8 = 70.
    push(4, 8'd1, 8'd5);
    push(4, 8'd2, 8'd6);
    @(negedge clk);
    chk("accum_in_ready",  {31'd0, r4},  32'd1);
    chk("accum_out_valid", {31'd0, ov4}, 32'd0);
    @(posedge clk); #1;
    push(4, 8'd3, 8'd7);
    push(4, 8'd4, 8'd8);
    @(negedge clk);
    chk("drain_out_valid", {31'd0, ov4}, 32'd0);
    chk("drain_in_ready",  {31'd0, r4},  32'd0);
    step();
    @(negedge clk);
    chk("basic_out_valid", {31'd0, ov4},  32'd1);
    chk("basic_sum",       {8'd0, sum4},  32'd70);
    chk("basic_overflow",  {31'd0, ovf4}, 32'd0);
    step();
    @(negedge clk);
    chk("basic_taken_valid", {31'd0, ov4}, 32'd0);
    chk("basic_taken_ready", {31'd0, r4},  32'd1);
    chk("basic_taken_sum",   {8'd0, sum4}, 32'd0);
    step();

    // Signed extremes: 4 * (-128 * -128) = 65536.
    repeat (4) push(4, 8'h80, 8'h80);
    step();
    @(negedge clk);
    chk("ext_valid", {31'd0, ov4},  32'd1);
    chk("ext_sum",   {8'd0, sum4},  32'h010000);
    chk("ext_ovf",   {31'd0, ovf4}, 32'd0);
    step();

    // Mixed signs: -5 - 12 + 0 - 12 = -29.
    push(4, 8'hFF, 8'd5);
    push(4, 8'd3,  8'hFC);
    push(4, 8'd0,  8'd9);
    push(4, 8'd2,  8'hFA);
    step();
    @(negedge clk);
    chk("mixed_valid", {31'd0, ov4}, 32'd1);
    chk("mixed_sum",   {8'd0, sum4}, 32'hFFFFE3);
    step();

    // Bubbles between pairs and result backpressure.
    or4 = 1'b0;
    push(4, 8'd1, 8'd5);
    step();
    push(4, 8'd2, 8'd6);
    step();
    step();
    push(4, 8'd3, 8'd7);
    push(4, 8'd4, 8'd8);
    step();
    // Junk on the input while held must be ignored.
    in_a = 8'h55; in_b = 8'h55; v4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, ov4}, 32'd1);
      chk("hold_sum",   {8'd0, sum4}, 32'd70);
      chk("hold_ready", {31'd0, r4},  32'd0);
      @(posedge clk); #1;
    end
    v4 = 1'b0;
    or4 = 1'b1;
    step();
    @(negedge clk);
    chk("release_valid", {31'd0, ov4}, 32'd0);
    chk("release_ready", {31'd0, r4},  32'd1);
    step();

    // Reset after two of four pairs; partial sum must vanish.
    push(4, 8'd10, 8'd10);
    push(4, 8'd20, 8'd20);
    rst = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, r4},   32'd1);
    chk("midrst_valid", {31'd0, ov4},  32'd0);
    chk("midrst_sum",   {8'd0, sum4},  32'd0);
    chk("midrst_ovf",   {31'd0, ovf4}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    push(4, 8'd1, 8'd1);
    push(4, 8'd2, 8'd2);
    push(4, 8'd3, 8'd3);
    push(4, 8'd4, 8'd4);
    step();
    @(negedge clk);
    chk("fresh_valid", {31'd0, ov4},  32'd1);
    chk("fresh_sum",   {8'd0, sum4},  32'd30);
    chk("fresh_ovf",   {31'd0, ovf4}, 32'd0);
    step();

    // VEC_LEN = 1: IDLE straight to DRAIN; 7 * -3 = -21.
    push(1, 8'd7, 8'hFD);
    @(negedge clk);
    chk("v1_drain_valid", {31'd0, ov1}, 32'd0);
    chk("v1_drain_ready", {31'd0, r1},  32'd0);
    step();
    @(negedge clk);
    chk("v1_valid", {31'd0, ov1}, 32'd1);
    chk("v1_sum",   {8'd0, sum1}, 32'hFFFFEB);
    step();
    @(negedge clk);
    chk("v1_taken", {31'd0, ov1}, 32'd0);
    step();

    // VEC_LEN = 600 of (-128 * -128): 9830400 wraps, overflow sticky.
    for (int i = 0; i < 600; i++) begin
      push(600, 8'h80, 8'h80);
    end
    step();
    @(negedge clk);
    chk("ovf_valid", {31'd0, ov6},  32'd1);
    chk("ovf_sum",   {8'd0, sum6},  32'h960000);
    chk("ovf_flag",  {31'd0, ovf6}, 32'd1);
    @(posedge clk); #1;
    or6 = 1'b1;
    step();
    @(negedge clk);
    chk("ovf_cleared", {31'd0, ovf6}, 32'd0);
    chk("ovf_idle",    {31'd0, r6},   32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
